// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default timing for the strobe checker
package div_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
  localparam int DEF_EXP_PERIOD = 4;
  localparam int DEF_LOCK_CNT = 3;
endpackage

// File: rtl/flag_ivl_cnt.sv
// flag_ivl_cnt: measures strobe spacing and detects a missing strobe
module flag_ivl_cnt #(
  parameter int EXP_PERIOD = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_flag,
  output logic [CNT_W-1:0] meas,
  output logic             timeout,
  output logic [CNT_W-1:0] period_meas,
  output logic             meas_vld
);
  logic [CNT_W-1:0] ivl_cnt;
  logic armed;
  assign armed = ivl_cnt != '0;
  assign meas = ivl_cnt;
  // counter runs past EXP_PERIOD, so this fires only once per gap
  assign timeout = !pi_flag && ivl_cnt == CNT_W'(EXP_PERIOD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_cnt <= '0;
      period_meas <= '0;
      meas_vld <= 1'b0;
    end else begin
      meas_vld <= pi_flag && armed;
      if (pi_flag && armed) period_meas <= ivl_cnt;
      if (pi_flag) ivl_cnt <= CNT_W'(1);
      else if (armed && ivl_cnt != '1) ivl_cnt <= ivl_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/div_flag_checker.sv
// div_flag_checker: lock/error monitor for a periodic single-cycle strobe
module div_flag_checker
  import div_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_flag,
  input  logic             err_clr,
  output logic             lock,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] period_meas,
  output logic             meas_vld
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  state_t state;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [CNT_W-1:0] meas;
  logic timeout, hit, err;
  flag_ivl_cnt #(.EXP_PERIOD(EXP_PERIOD), .CNT_W(CNT_W)) u_ivl (
    .clk(clk),
    .rst_n(rst_n),
    .pi_flag(pi_flag),
    .meas(meas),
    .timeout(timeout),
    .period_meas(period_meas),
    .meas_vld(meas_vld)
  );
  assign hit = meas == CNT_W'(EXP_PERIOD);
  assign good_nxt = good_cnt + 1'b1;
  assign err = state == LOCK && ((pi_flag && !hit) || timeout);
  assign lock = state == LOCK;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      good_cnt <= '0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_pulse <= err;
      // clear wins over the old count, but a coincident error still counts
      err_cnt <= err_clr ? ERR_W'(err) : err_cnt + ERR_W'(err && err_cnt != '1);
      case (state)
        IDLE: if (pi_flag) begin
          state <= ACQ;
          good_cnt <= '0;
        end
        ACQ: if (pi_flag && hit) begin
          good_cnt <= good_nxt;
          if (good_nxt == GW'(LOCK_CNT)) state <= LOCK;
        end else if (pi_flag || timeout) good_cnt <= '0;
        LOCK: if (err) begin
          state <= ACQ;
          good_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
